// File: rtl/parity_pkg.sv
// Shared definitions for the reduction-parity path (transmitter, receiver, checkers).
package parity_pkg;

  // Receiver frame states: start bit sampled in IDLE, then data, parity, stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Widest vector the parity helper accepts; narrower vectors are zero-extended,
  // which leaves the reduction XOR unchanged.
  localparam int unsigned PARITY_MAX_W = 64;

  // Even parity (odd=0) is ^vec; odd parity (odd=1) is ~^vec.
  function automatic logic reduce_parity(input logic [PARITY_MAX_W-1:0] vec,
                                         input logic                    odd);
    return (^vec) ^ odd;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator with synchronous clear and enable; clear wins over enable.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  // Running XOR of every enabled bit since the last clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial parity-frame receiver: start bit, DATA_W data bits (LSB first), parity,
// stop. Recomputes the reduction parity and reports parity and framing errors
// alongside the received word with a single-cycle valid pulse.
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  input  logic              rx_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  rx_state_e         state;
  rx_state_e         state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic              acc_q;
  logic              acc_clr;
  logic              acc_en;
  logic              last_bit;
  logic              start_seen;
  logic              data_step;
  logic              load_out;

  // New bits enter at the MSB so the first (LSB) bit ends up at bit 0.
  if (DATA_W == 1) begin : g_shift_one
    assign shift_nxt = rx_bit;
  end else begin : g_shift_many
    assign shift_nxt = {rx_bit, shift_q[DATA_W-1:1]};
  end

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-strobe control; nothing advances without rx_en.
  always_comb begin
    state_nxt  = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    start_seen = 1'b0;
    data_step  = 1'b0;
    load_out   = 1'b0;
    last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
    if (rx_en) begin
      case (state)
        IDLE: begin
          if (!rx_bit) begin
            start_seen = 1'b1;
            acc_clr    = 1'b1;
            state_nxt  = DATA;
          end
        end
        DATA: begin
          data_step = 1'b1;
          acc_en    = 1'b1;
          if (last_bit) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          acc_en    = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          load_out  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Data bit counter: cleared on the start bit, stops at DATA_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (start_seen) begin
      bit_cnt <= '0;
    end else if (data_step) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Deserializing shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (data_step) begin
      shift_q <= shift_nxt;
    end
  end

  // Parity over data bits plus the received parity bit.
  parity_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (rx_bit),
    .acc    (acc_q)
  );

  // Result registers load together on the stop-bit strobe and hold until the
  // next completed frame; the valid strobe drops on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= load_out;
      if (load_out) begin
        data_out   <= shift_q;
        parity_err <= acc_q ^ ODD_PARITY;
        frame_err  <= ~rx_bit;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: an even-parity and an odd-parity instance,
// directed line patterns with hand-computed expected words.
module tb_parity_frame_rx;

  typedef struct packed {
    logic [3:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_e, en_e, rx_o, en_o;
  logic [3:0] dout_e, dout_o;
  logic       dv_e, pe_e, fe_e, busy_e;
  logic       dv_o, pe_o, fe_o, busy_o;

  int n_vec = 0;
  int n_bad = 0;
  exp_t q_e[$];
  exp_t q_o[$];

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(4), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst(rst), .rx_bit(rx_e), .rx_en(en_e),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e),
    .frame_err(fe_e), .busy(busy_e)
  );

  parity_frame_rx #(.DATA_W(4), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst(rst), .rx_bit(rx_o), .rx_en(en_o),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o),
    .frame_err(fe_o), .busy(busy_o)
  );

  // Monitor: every valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t x;
    if (dv_e) begin
      n_vec++;
      if (q_e.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid_e got d=%b pe=%b fe=%b required no valid", dout_e, pe_e, fe_e);
      end else begin
        x = q_e.pop_front();
        if (dout_e !== x.d || pe_e !== x.pe || fe_e !== x.fe) begin
          n_bad++;
          $display("FAIL frame_e got d=%b pe=%b fe=%b required d=%b pe=%b fe=%b",
                   dout_e, pe_e, fe_e, x.d, x.pe, x.fe);
        end
      end
    end
    if (dv_o) begin
      n_vec++;
      if (q_o.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid_o got d=%b pe=%b fe=%b required no valid", dout_o, pe_o, fe_o);
      end else begin
        x = q_o.pop_front();
        if (dout_o !== x.d || pe_o !== x.pe || fe_o !== x.fe) begin
          n_bad++;
          $display("FAIL frame_o got d=%b pe=%b fe=%b required d=%b pe=%b fe=%b",
                   dout_o, pe_o, fe_o, x.d, x.pe, x.fe);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got %b required %b", name, got, req);
    end
  endtask

  // Drive one frame (line[0] = start bit) on the even instance. sparse inserts an
  // rx_en=0 cycle before every bit after the start; stall_at inserts three more
  // rx_en=0 cycles before that bit, during which the held outputs are checked.
  task automatic send_e(input logic [6:0] line, input bit sparse, input int stall_at,
                        input logic [3:0] held_d);
    for (int i = 0; i < 7; i++) begin
      if (sparse && i > 0) begin
        @(negedge clk); en_e = 1'b0; rx_e = ~line[i];
        if (i == 1) check("busy_after_start", {7'd0, busy_e}, 8'd1);
      end
      if (i == stall_at) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); en_e = 1'b0; rx_e = 1'b0;
          check("stall_hold", {1'b0, busy_e, dv_e, pe_e, dout_e}, {3'b010, 1'b0, held_d});
        end
      end
      @(negedge clk);
      if (i == 0) check("busy_before_start", {7'd0, busy_e}, 8'd0);
      if (i == 1 && !sparse && stall_at != 1) check("busy_after_start", {7'd0, busy_e}, 8'd1);
      en_e = 1'b1; rx_e = line[i];
    end
  endtask

  task automatic send_o(input logic [6:0] line);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); en_o = 1'b1; rx_o = line[i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); en_e = 1'b1; rx_e = 1'b1; en_o = 1'b1; rx_o = 1'b1;
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1; rx_e = 1'b1; en_e = 1'b0; rx_o = 1'b1; en_o = 1'b0;
    @(negedge clk); @(negedge clk);
    check("reset_e", {1'b0, busy_e, dv_e, pe_e, fe_e, dout_e[2:0]}, 8'd0);
    check("reset_e_d3", {7'd0, dout_e[3]}, 8'd0);
    check("reset_o", {1'b0, busy_o, dv_o, pe_o, fe_o, dout_o[2:0]}, 8'd0);
    rst = 1'b0;
    idle(2);

    // Even, clean 0101, then 1111 with wrong parity back-to-back.
    q_e.push_back('{d: 4'b0101, pe: 1'b0, fe: 1'b0});
    send_e(7'b1001010, 1'b0, -1, 4'b0000);
    q_e.push_back('{d: 4'b1111, pe: 1'b1, fe: 1'b0});
    send_e(7'b1111110, 1'b0, -1, 4'b0000);
    idle(2);

    // Reset after two data bits: outputs clear immediately, no valid for the partial frame.
    @(negedge clk); en_e = 1'b1; rx_e = 1'b0;
    @(negedge clk); rx_e = 1'b1;
    @(negedge clk); rx_e = 1'b1;
    @(negedge clk); rx_e = 1'b0;
    check("busy_mid_frame", {7'd0, busy_e}, 8'd1);
    check("held_before_rst", {3'b0, pe_e, dout_e}, {3'b0, 1'b1, 4'b1111});
    #2 rst = 1'b1;
    #1 check("async_reset", {1'b0, busy_e, dv_e, pe_e, fe_e, dout_e[2:0]}, 8'd0);
    check("async_reset_d3", {7'd0, dout_e[3]}, 8'd0);
    @(negedge clk); rst = 1'b0; en_e = 1'b1; rx_e = 1'b1;
    idle(1);

    // Clean 0011 after the reset.
    q_e.push_back('{d: 4'b0011, pe: 1'b0, fe: 1'b0});
    send_e(7'b1000110, 1'b0, -1, 4'b0000);
    idle(1);

    // Sparse strobes plus a 3-cycle stall mid-data; held outputs are the 0011 frame.
    q_e.push_back('{d: 4'b0101, pe: 1'b0, fe: 1'b0});
    send_e(7'b1001010, 1'b1, 3, 4'b0011);
    @(negedge clk); en_e = 1'b0; rx_e = 1'b1;
    idle(1);

    // Framing error, then an immediate start of the next frame.
    q_e.push_back('{d: 4'b0011, pe: 1'b0, fe: 1'b1});
    send_e(7'b0000110, 1'b0, -1, 4'b0000);
    q_e.push_back('{d: 4'b0000, pe: 1'b0, fe: 1'b0});
    send_e(7'b1000000, 1'b0, -1, 4'b0000);
    idle(2);

    // Odd parity: correct parity bit 1, then parity bit 0.
    q_o.push_back('{d: 4'b0000, pe: 1'b0, fe: 1'b0});
    send_o(7'b1100000);
    q_o.push_back('{d: 4'b0000, pe: 1'b1, fe: 1'b0});
    send_o(7'b1000000);
    idle(2);

    waited = 0;
    while ((q_e.size() != 0 || q_o.size() != 0) && waited < 50) begin
      @(negedge clk); waited++;
    end
    check("pending_even", 8'(q_e.size()), 8'd0);
    check("pending_odd", 8'(q_o.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
